piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out front end for the serial sequence-detector FSMs.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per enabled clock on ser_out.
//  ser_out drives the detector's d_in. A holding buffer plus a shift register give gap-free back-to-back streaming.
// PARAMETERS
//  WIDTH       8   word width in bits (>=2); bit counter is $clog2(WIDTH) wide
//  MSB_FIRST   1   1: shift out bit WIDTH-1 first; 0: bit 0 first
//  IDLE_LEVEL  0   ser_out level while no word is being shifted
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      in_data holds a word to transfer
//  in_data     in   WIDTH  parallel word
//  in_ready    out  1      block can take a word this cycle
//  bit_en      in   1      consumer takes the current ser_out bit at this edge
//  ser_out     out  1      serial data bit (registered source)
//  ser_valid   out  1      ser_out carries a data bit
//  ser_first   out  1      current bit is bit 0 of the word in flight
//  ser_last    out  1      current bit is bit WIDTH-1 of the word in flight
//  busy        out  1      word in shift register or holding buffer
// BEHAVIOUR
//  Storage: holding buffer HB with flag hb_full; shift register SR; bit counter cnt; state IDLE/SHIFT.
//  Reset (rst=1 at edge): state=IDLE, hb_full=0, cnt=0, SR=0, HB=0.
//   While rst=1: in_ready=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, ser_out=IDLE_LEVEL.
//  Drain condition: load = hb_full && (state==IDLE || (state==SHIFT && bit_en && cnt==WIDTH-1)).
//  in_ready = !rst && (!hb_full || load). No combinational path from in_valid to in_ready.
//  Accept: at an edge with in_valid && in_ready, HB<=in_data and hb_full<=1.
//   Simultaneous load+accept: SR takes the old HB, HB takes the new word, hb_full stays 1.
//  Load: at a load edge, SR<=HB, cnt<=0, state<=SHIFT; hb_full<=0 unless accepting at the same edge.
//  Shift: in SHIFT, each edge with bit_en=1 and cnt<WIDTH-1 does cnt+=1 and shifts SR one place.
//   Shift direction follows MSB_FIRST.
//   Edges with bit_en=0 hold ser_out, cnt and SR unchanged.
//  End of word: edge with bit_en=1, cnt==WIDTH-1:
//   - load condition true -> next word starts with no gap;
//   - HB empty -> state<=IDLE (underrun).
//  Outputs, all decoded from registers:
//   ser_valid = (state==SHIFT).
//   ser_out = MSB_FIRST ? SR[WIDTH-1] : SR[0] in SHIFT, IDLE_LEVEL in IDLE.
//   ser_first = SHIFT && cnt==0.
//   ser_last = SHIFT && cnt==WIDTH-1.
//   busy = (state==SHIFT) || hb_full.
//  Latency: with block idle, a word accepted at edge k is in HB after k, loads SR at k+1, and first bit is on ser_out after k+1.
//  Throughput: with bit_en=1 continuously, one word per WIDTH cycles and no idle bits between words.
//  in_data is sampled only at the accept edge; later changes have no effect.
//  Reset mid-word discards SR and HB contents. No partial bits are emitted after reset.
// TESTING
//  1 W=8, MSB_FIRST=1, bit_en=1, send 8'hB0 -> ser_out 1,0,1,1,0,0,0,0 starting 2 cycles after accept.
//    ser_first on bit 1, ser_last on bit 8. Drive into the 1011 detector -> one pattern_detect pulse.
//  2 Send 8'hA5 then 8'h3C, in_valid held -> 16 consecutive ser_valid cycles with bits 10100101_00111100.
//    in_ready is 0 while HB is full and not draining.
//  3 bit_en high 1 cycle in 3, word 8'hC3 -> each bit held 3 cycles, order 11000011 unchanged, 24 cycles of ser_valid.
//  4 MSB_FIRST=0, word 8'h01 -> ser_out 1 then seven 0s.
//  5 rst pulsed after 3 bits of 8'hFF with HB full -> next cycle ser_valid=0, ser_out=IDLE_LEVEL, busy=0.
//    After rst release: in_ready=1 and no leftover bits appear.
//  6 Single word 8'h0F then in_valid=0 -> ser_valid falls the cycle after the ser_last bit is taken; busy=0 on the same cycle.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end: a holding buffer feeds a shift register so
// consecutive words stream out one bit per enabled clock with no idle bits.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] hb;
    logic [WIDTH-1:0] hb_nxt;
    logic             hb_full;
    logic             hb_full_nxt;
    logic             at_last;
    logic             load;
    logic             accept;

    // Move the register one place so the next outgoing bit sits at the output tap.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    // Handshake and next-state decode; in_ready depends only on registers, bit_en and rst.
    always_comb begin
        at_last     = (cnt == CNT_LAST);
        load        = hb_full && ((state == ST_IDLE) ||
                                  ((state == ST_SHIFT) && bit_en && at_last));
        in_ready    = !rst && (!hb_full || load);
        accept      = in_valid && in_ready;

        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_nxt      = sr;
        hb_nxt      = hb;
        hb_full_nxt = hb_full;

        if (accept) begin
            hb_nxt      = in_data;
            hb_full_nxt = 1'b1;
        end

        if (load) begin
            sr_nxt    = hb;
            cnt_nxt   = '0;
            state_nxt = ST_SHIFT;
            if (!accept)
                hb_full_nxt = 1'b0;
        end else if ((state == ST_SHIFT) && bit_en) begin
            if (at_last) begin
                state_nxt = ST_IDLE;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
                sr_nxt  = shift_one(sr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sr      <= '0;
            hb      <= '0;
            hb_full <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sr      <= sr_nxt;
            hb      <= hb_nxt;
            hb_full <= hb_full_nxt;
        end
    end

    // Outputs decode registered state; rst forces them quiet even before the reset edge.
    always_comb begin
        ser_valid = !rst && (state == ST_SHIFT);
        ser_first = ser_valid && (cnt == '0);
        ser_last  = ser_valid && at_last;
        busy      = !rst && ((state == ST_SHIFT) || hb_full);
        ser_out   = IDLE_LEVEL;
        if (ser_valid)
            ser_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus
// and are compared every cycle against a word/bit-index model, plus literal checks.
module tb_piso_serializer;

    localparam int W      = 8;
    localparam bit IDLE_L = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         bit_en;

    logic in_ready, ser_out, ser_valid, ser_first, ser_last, busy;
    logic l_in_ready, l_ser_out, l_ser_valid, l_ser_first, l_ser_last, l_busy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_en(bit_en), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
        .busy(busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_L)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_in_ready), .bit_en(bit_en), .ser_out(l_ser_out),
        .ser_valid(l_ser_valid), .ser_first(l_ser_first), .ser_last(l_ser_last),
        .busy(l_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_bit(input string name, input logic got, input logic want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b, want %b at %0t", name, got, want, $time);
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    endtask

    // Model: the word in flight with the number of bits already taken, and an optional pending word.
    bit           m_act = 1'b0;
    int           m_idx = 0;
    logic [W-1:0] m_word = '0;
    bit           m_hbv = 1'b0;
    logic [W-1:0] m_hb = '0;
    bit           chk_on = 1'b0;

    always @(posedge clk) begin : model
        bit           drain, acc, act, hbv;
        int           idx;
        logic [W-1:0] word;
        act  = m_act;
        idx  = m_idx;
        word = m_word;
        hbv  = m_hbv;
        if (rst) begin
            act = 1'b0;
            idx = 0;
            hbv = 1'b0;
        end else begin
            drain = m_hbv && (!m_act || (bit_en && m_idx == W - 1));
            acc   = in_valid && (!m_hbv || drain);
            if (m_act && bit_en) begin
                if (m_idx == W - 1) act = 1'b0;
                else idx = m_idx + 1;
            end
            if (drain) begin
                word = m_hb;
                idx  = 0;
                act  = 1'b1;
                hbv  = 1'b0;
            end
            if (acc) begin
                m_hb <= in_data;
                hbv = 1'b1;
            end
        end
        m_act  <= act;
        m_idx  <= idx;
        m_word <= word;
        m_hbv  <= hbv;
        chk_on <= 1'b1;
    end

    bit cap_m[$];
    bit cap_l[$];
    int nvalid = 0;

    always @(negedge clk) begin : compare
        bit ev, drain_now, e_out_m, e_out_l, e_busy, e_rdy;
        if (chk_on) begin
            ev        = !rst && m_act;
            drain_now = m_hbv && (!m_act || (bit_en && m_idx == W - 1));
            e_out_m   = ev ? m_word[W-1-m_idx] : IDLE_L;
            e_out_l   = ev ? m_word[m_idx] : IDLE_L;
            e_busy    = !rst && (m_act || m_hbv);
            e_rdy     = !rst && (!m_hbv || drain_now);
            chk_bit("ser_valid", ser_valid, ev);
            chk_bit("ser_out", ser_out, e_out_m);
            chk_bit("ser_first", ser_first, ev && m_idx == 0);
            chk_bit("ser_last", ser_last, ev && m_idx == W - 1);
            chk_bit("busy", busy, e_busy);
            chk_bit("in_ready", in_ready, e_rdy);
            chk_bit("lsb_ser_valid", l_ser_valid, ev);
            chk_bit("lsb_ser_out", l_ser_out, e_out_l);
            chk_bit("lsb_ser_first", l_ser_first, ev && m_idx == 0);
            chk_bit("lsb_ser_last", l_ser_last, ev && m_idx == W - 1);
            chk_bit("lsb_busy", l_busy, e_busy);
            chk_bit("lsb_in_ready", l_in_ready, e_rdy);
        end
        if (ser_valid) nvalid++;
        if (ser_valid && bit_en) cap_m.push_back(ser_out);
        if (l_ser_valid && bit_en) cap_l.push_back(l_ser_out);
    end

    int en_mode = 0;
    int ph = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (en_mode)
            0:       bit_en = 1'b1;
            1: begin
                bit_en = (ph == 2);
                ph = (ph + 1) % 3;
            end
            default: bit_en = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic send(input logic [W-1:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_data  = W'($urandom);
        if (!done) chk_bit("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic clear_cap();
        cap_m.delete();
        cap_l.delete();
        nvalid = 0;
    endtask

    function automatic logic [31:0] qval(input bit q[$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    function automatic int count_1011(input bit q[$]);
        int n;
        n = 0;
        for (int i = 0; i + 3 < q.size(); i++)
            if (q[i] && !q[i+1] && q[i+2] && q[i+3]) n++;
        return n;
    endfunction

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        bit_en   = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk_bit("reset_in_ready", in_ready, 1'b0);
        chk_bit("reset_ser_out", ser_out, IDLE_L);
        chk_bit("reset_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_bit("post_reset_in_ready", in_ready, 1'b1);

        // Single word 0xB0, bit_en always high.
        en_mode = 0;
        tick();
        clear_cap();
        send(8'hB0);
        @(negedge clk);
        chk_bit("t1_hb_stage_valid", ser_valid, 1'b0);
        chk_bit("t1_hb_stage_busy", busy, 1'b1);
        tick();
        @(negedge clk);
        chk_bit("t1_first_bit_valid", ser_valid, 1'b1);
        chk_bit("t1_first_bit_flag", ser_first, 1'b1);
        repeat (12) tick();
        chk_val("t1_bits_msb", qval(cap_m), 32'hB0);
        chk_val("t1_bits_lsb", qval(cap_l), 32'h0D);
        chk_val("t1_nbits", cap_m.size(), 8);
        chk_val("t1_valid_cycles", nvalid, 8);
        chk_val("t1_detect_1011", count_1011(cap_m), 1);

        // Back-to-back words with in_valid held.
        clear_cap();
        send(8'hA5);
        send(8'h3C);
        @(negedge clk);
        chk_bit("t2_ready_low_hb_full", in_ready, 1'b0);
        repeat (22) tick();
        chk_val("t2_bits", qval(cap_m), 32'hA53C);
        chk_val("t2_valid_cycles", nvalid, 16);

        // bit_en one cycle in three.
        clear_cap();
        en_mode = 1;
        ph = 2;
        send(8'hC3);
        repeat (40) tick();
        chk_val("t3_bits", qval(cap_m), 32'hC3);
        chk_val("t3_valid_cycles", nvalid, 24);

        // LSB-first instance with 0x01.
        en_mode = 0;
        tick();
        clear_cap();
        send(8'h01);
        repeat (12) tick();
        chk_val("t4_bits_lsb", qval(cap_l), 32'h80);
        chk_val("t4_bits_msb", qval(cap_m), 32'h01);

        // Single word then idle: valid and busy drop right after the last bit.
        send(8'h0F);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ser_last) break;
            tick();
        end
        chk_bit("t6_saw_last", ser_last, 1'b1);
        tick();
        @(negedge clk);
        chk_bit("t6_valid_drop", ser_valid, 1'b0);
        chk_bit("t6_busy_drop", busy, 1'b0);

        // Reset mid-word with the holding buffer full.
        send(8'hFF);
        send(8'h55);
        tick();
        tick();
        @(negedge clk);
        chk_bit("t5_busy_before", busy, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_bit("t5_valid", ser_valid, 1'b0);
        chk_bit("t5_ser_out", ser_out, IDLE_L);
        chk_bit("t5_busy", busy, 1'b0);
        chk_bit("t5_in_ready", in_ready, 1'b1);
        clear_cap();
        repeat (20) tick();
        chk_val("t5_no_leftover", nvalid, 0);

        // Random traffic, random bit_en and occasional resets.
        en_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            tick();
            in_valid = ($urandom_range(3) != 0);
            in_data  = W'($urandom);
            rst      = ($urandom_range(299) == 0);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
